// File: rtl/stopwatch_core_if.sv
// Command/status bundle between the pushbutton front end and stopwatch_core.
// master drives the button pulses and preset; slave is the stopwatch core.
interface stopwatch_core_if;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic        dir;
    logic        load_en;
    logic [23:0] load_value;
    logic [23:0] disp;
    logic        running;
    logic        lap_active;
    logic        expired;
    logic        wrap;
    logic        load_err;

    modport master (
        output start_stop, clear, lap, dir, load_en, load_value,
        input  disp, running, lap_active, expired, wrap, load_err
    );

    modport slave (
        input  start_stop, clear, lap, dir, load_en, load_value,
        output disp, running, lap_active, expired, wrap, load_err
    );
endinterface

// File: rtl/stopwatch_core.sv
// BCD MM:SS.CC stopwatch/countdown: centisecond prescaler, IDLE/RUN/PAUSE/EXPIRED FSM, preset load.
// Define STOPWATCH_LAP_EN to build the lap capture register; otherwise disp is always live.
module stopwatch_core #(
    parameter int TICK_DIV = 1_000_000,
    parameter int MIN_MAX  = 59
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_core_if.slave bus
);
    localparam int               PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]       MIN_MAX_V  = 7'(MIN_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t        state_r;
    logic [23:0]   count_r;
    logic [PW-1:0] presc_r;
    logic [23:0]   disp_r;
    logic          running_r;
    logic          expired_r;
    logic          wrap_r;
    logic          load_err_r;

    logic [24:0]   up_s;
    logic [23:0]   dn_s;
    logic          load_ok_s;
    logic          cmd_load_s;
    logic          cmd_start_s;
    logic          idle_go_s;
    logic          tick_s;
    logic          tick_wrap_s;
    logic          tick_exp_s;
    logic [23:0]   count_nxt_s;
    logic [PW-1:0] presc_nxt_s;
    logic [23:0]   disp_nxt_s;

    function automatic logic [6:0] min_val(input logic [3:0] m1, input logic [3:0] m0);
        return ({3'b000, m1} * 7'd10) + {3'b000, m0};
    endfunction

    function automatic logic bcd_valid(input logic [23:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        if ((v[15:12] > 4'd5) || (ok && (min_val(v[23:20], v[19:16]) > MIN_MAX_V))) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    // Increment with per-field carry; bit 24 flags the MIN_MAX:59.99 rollover.
    function automatic logic [24:0] bcd_up(input logic [23:0] v);
        logic [3:0] m1, m0, s1, s0, c1, c0;
        logic       w;
        {m1, m0, s1, s0, c1, c0} = v;
        w = 1'b0;
        if (c0 != 4'd9) begin
            c0 = c0 + 4'd1;
        end else begin
            c0 = 4'd0;
            if (c1 != 4'd9) begin
                c1 = c1 + 4'd1;
            end else begin
                c1 = 4'd0;
                if (s0 != 4'd9) begin
                    s0 = s0 + 4'd1;
                end else begin
                    s0 = 4'd0;
                    if (s1 != 4'd5) begin
                        s1 = s1 + 4'd1;
                    end else begin
                        s1 = 4'd0;
                        if (min_val(m1, m0) >= MIN_MAX_V) begin
                            m1 = 4'd0;
                            m0 = 4'd0;
                            w  = 1'b1;
                        end else if (m0 != 4'd9) begin
                            m0 = m0 + 4'd1;
                        end else begin
                            m0 = 4'd0;
                            m1 = m1 + 4'd1;
                        end
                    end
                end
            end
        end
        return {w, m1, m0, s1, s0, c1, c0};
    endfunction

    // Decrement with per-field borrow; a zero count saturates instead of going negative.
    function automatic logic [23:0] bcd_dn(input logic [23:0] v);
        logic [3:0] m1, m0, s1, s0, c1, c0;
        {m1, m0, s1, s0, c1, c0} = v;
        if (v != 24'd0) begin
            if (c0 != 4'd0) begin
                c0 = c0 - 4'd1;
            end else begin
                c0 = 4'd9;
                if (c1 != 4'd0) begin
                    c1 = c1 - 4'd1;
                end else begin
                    c1 = 4'd9;
                    if (s0 != 4'd0) begin
                        s0 = s0 - 4'd1;
                    end else begin
                        s0 = 4'd9;
                        if (s1 != 4'd0) begin
                            s1 = s1 - 4'd1;
                        end else begin
                            s1 = 4'd5;
                            if (m0 != 4'd0) begin
                                m0 = m0 - 4'd1;
                            end else begin
                                m0 = 4'd9;
                                m1 = m1 - 4'd1;
                            end
                        end
                    end
                end
            end
        end else begin
            c0 = 4'd0;
        end
        return {m1, m0, s1, s0, c1, c0};
    endfunction

    // Command decode by priority, tick detection and next count/prescaler values.
    always_comb begin
        up_s        = bcd_up(count_r);
        dn_s        = bcd_dn(count_r);
        load_ok_s   = bcd_valid(bus.load_value);
        cmd_load_s  = bus.load_en && !bus.clear && (state_r != S_RUN);
        cmd_start_s = bus.start_stop && !bus.clear && !cmd_load_s;
        idle_go_s   = cmd_start_s && (state_r == S_IDLE) && !(bus.dir && (count_r == 24'd0));
        tick_s      = (state_r == S_RUN) && (presc_r == PRESC_LAST) && !bus.clear;
        tick_wrap_s = tick_s && !bus.dir && up_s[24];
        tick_exp_s  = tick_s && bus.dir && (dn_s == 24'd0);

        if (bus.clear) begin
            count_nxt_s = 24'd0;
        end else if (cmd_load_s && load_ok_s) begin
            count_nxt_s = bus.load_value;
        end else if (tick_s && bus.dir) begin
            count_nxt_s = dn_s;
        end else if (tick_s) begin
            count_nxt_s = up_s[23:0];
        end else begin
            count_nxt_s = count_r;
        end

        // The prescaler only restarts from IDLE, so a pause keeps the partial tick.
        if (bus.clear || idle_go_s || tick_s) begin
            presc_nxt_s = {PW{1'b0}};
        end else if (state_r == S_RUN) begin
            presc_nxt_s = presc_r + PW'(1);
        end else begin
            presc_nxt_s = presc_r;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [23:0] lap_val_r;
    logic        lap_act_r;
    logic [23:0] lap_val_nxt_s;
    logic        lap_act_nxt_s;
    logic        cmd_lap_s;

    // Lap captures the pre-edge live count in RUN and releases in any other state.
    always_comb begin
        cmd_lap_s = bus.lap && !bus.clear && !cmd_load_s && !bus.start_stop;
        if (bus.clear) begin
            lap_act_nxt_s = 1'b0;
            lap_val_nxt_s = 24'd0;
        end else if (cmd_lap_s && (state_r == S_RUN)) begin
            lap_act_nxt_s = 1'b1;
            lap_val_nxt_s = count_r;
        end else if (cmd_lap_s) begin
            lap_act_nxt_s = 1'b0;
            lap_val_nxt_s = lap_val_r;
        end else begin
            lap_act_nxt_s = lap_act_r;
            lap_val_nxt_s = lap_val_r;
        end
        disp_nxt_s = lap_act_nxt_s ? lap_val_nxt_s : count_nxt_s;
    end

    // Lap capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_val_r <= 24'd0;
            lap_act_r <= 1'b0;
        end else begin
            lap_val_r <= lap_val_nxt_s;
            lap_act_r <= lap_act_nxt_s;
        end
    end

    assign bus.lap_active = lap_act_r;
`else
    logic lap_unused_s;
    assign lap_unused_s   = bus.lap;
    assign disp_nxt_s     = count_nxt_s;
    assign bus.lap_active = 1'b0;
`endif

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            count_r    <= 24'd0;
            presc_r    <= {PW{1'b0}};
            disp_r     <= 24'd0;
            running_r  <= 1'b0;
            expired_r  <= 1'b0;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            presc_r    <= presc_nxt_s;
            disp_r     <= disp_nxt_s;
            expired_r  <= tick_exp_s;
            wrap_r     <= tick_wrap_s;
            load_err_r <= cmd_load_s && !load_ok_s;
            if (bus.clear) begin
                state_r   <= S_IDLE;
                running_r <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (idle_go_s) begin
                            state_r   <= S_RUN;
                            running_r <= 1'b1;
                        end else begin
                            state_r   <= S_IDLE;
                            running_r <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (tick_exp_s) begin
                            state_r   <= S_EXPIRED;
                            running_r <= 1'b0;
                        end else if (cmd_start_s) begin
                            state_r   <= S_PAUSE;
                            running_r <= 1'b0;
                        end else begin
                            state_r   <= S_RUN;
                            running_r <= 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (cmd_start_s) begin
                            state_r   <= S_RUN;
                            running_r <= 1'b1;
                        end else begin
                            state_r   <= S_PAUSE;
                            running_r <= 1'b0;
                        end
                    end
                    S_EXPIRED: begin
                        if (cmd_load_s && load_ok_s) begin
                            state_r <= S_IDLE;
                        end else begin
                            state_r <= S_EXPIRED;
                        end
                        running_r <= 1'b0;
                    end
                    default: begin
                        state_r   <= S_IDLE;
                        running_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.disp     = disp_r;
    assign bus.running  = running_r;
    assign bus.expired  = expired_r;
    assign bus.wrap     = wrap_r;
    assign bus.load_err = load_err_r;
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus $urandom pulses, checked every cycle
// against a model that keeps the count as total centiseconds and ticks on absolute edge numbers.
module tb_stopwatch_core;
    localparam int TD   = 4;
    localparam int MM   = 59;
    localparam int MAXT = MM * 6000 + 5999;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_EXP = 3;

    logic clk;
    logic reset;
    stopwatch_core_if bus_if ();

    stopwatch_core #(.TICK_DIV(TD), .MIN_MAX(MM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;
    logic dir_v    = 1'b0;

    int   m_state, m_total, m_next_tick, m_left, m_lap_total;
    logic m_lap_act, m_exp, m_wrap, m_lerr;

    task automatic check_eq(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at edge %0d", tag, obs, exp_v, edge_n);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int t);
        int cs, s, m;
        cs = t % 100;
        s  = (t / 100) % 60;
        m  = t / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic bit load_legal(input logic [23:0] v);
        for (int i = 0; i < 6; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        if (v[15:12] > 4'd5) return 1'b0;
        return (int'(v[23:20]) * 10 + int'(v[19:16])) <= MM;
    endfunction

    function automatic int bcd_to_cs(input logic [23:0] v);
        int m, s, c;
        m = int'(v[23:20]) * 10 + int'(v[19:16]);
        s = int'(v[15:12]) * 10 + int'(v[11:8]);
        c = int'(v[7:4]) * 10 + int'(v[3:0]);
        return (m * 60 + s) * 100 + c;
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_total = 0; m_next_tick = 0; m_left = 0;
        m_lap_act = 1'b0; m_lap_total = 0; m_exp = 1'b0; m_wrap = 1'b0; m_lerr = 1'b0;
    endtask

    task automatic model_step(input logic ss, input logic clr, input logic lp,
                              input logic d, input logic ld, input logic [23:0] lv);
        int   old_total, old_state;
        logic cmd_load, cmd_start, cmd_lap, tick;
        m_exp = 1'b0; m_wrap = 1'b0; m_lerr = 1'b0;
        if (clr) begin
            m_state = ST_IDLE; m_total = 0; m_lap_act = 1'b0; m_lap_total = 0;
        end else begin
            old_total = m_total;
            old_state = m_state;
            cmd_load  = ld && (old_state != ST_RUN);
            cmd_start = ss && !cmd_load;
            cmd_lap   = lp && !cmd_load && !ss;
            tick      = (old_state == ST_RUN) && (edge_n == m_next_tick);
            if (tick) begin
                m_next_tick = edge_n + TD;
                if (!d) begin
                    if (m_total == MAXT) begin m_total = 0; m_wrap = 1'b1; end
                    else m_total++;
                end else begin
                    if (m_total > 0) m_total--;
                    if (m_total == 0) begin m_exp = 1'b1; m_state = ST_EXP; end
                end
            end
            if (cmd_load) begin
                if (load_legal(lv)) begin
                    m_total = bcd_to_cs(lv);
                    if (old_state == ST_EXP) m_state = ST_IDLE;
                end else m_lerr = 1'b1;
            end
            if (cmd_start) begin
                if (old_state == ST_IDLE && !(d && old_total == 0)) begin
                    m_state = ST_RUN; m_next_tick = edge_n + TD;
                end else if (old_state == ST_RUN && m_state == ST_RUN) begin
                    m_state = ST_PAUSE; m_left = m_next_tick - edge_n;
                end else if (old_state == ST_PAUSE) begin
                    m_state = ST_RUN; m_next_tick = edge_n + m_left;
                end
            end
`ifdef STOPWATCH_LAP_EN
            if (cmd_lap) begin
                if (old_state == ST_RUN) begin m_lap_act = 1'b1; m_lap_total = old_total; end
                else m_lap_act = 1'b0;
            end
`else
            if (cmd_lap) m_lap_act = 1'b0;
`endif
        end
    endtask

    task automatic compare_all();
        check_eq("disp",       bus_if.disp, m_lap_act ? to_bcd(m_lap_total) : to_bcd(m_total));
        check_eq("running",    {23'd0, bus_if.running},    {23'd0, (m_state == ST_RUN)});
        check_eq("lap_active", {23'd0, bus_if.lap_active}, {23'd0, m_lap_act});
        check_eq("expired",    {23'd0, bus_if.expired},    {23'd0, m_exp});
        check_eq("wrap",       {23'd0, bus_if.wrap},       {23'd0, m_wrap});
        check_eq("load_err",   {23'd0, bus_if.load_err},   {23'd0, m_lerr});
    endtask

    task automatic cycle(input logic ss, input logic clr, input logic lp,
                         input logic ld, input logic [23:0] lv);
        @(negedge clk);
        bus_if.start_stop = ss;
        bus_if.clear      = clr;
        bus_if.lap        = lp;
        bus_if.load_en    = ld;
        bus_if.load_value = lv;
        bus_if.dir        = dir_v;
        @(posedge clk);
        edge_n++;
        model_step(ss, clr, lp, dir_v, ld, lv);
        #1;
        compare_all();
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom));
    endtask

    function automatic logic [23:0] gen_load();
        logic [23:0] v;
        int          m;
        case ($urandom_range(0, 5))
            0: v = to_bcd(int'($urandom_range(0, MAXT)));
            1: v = to_bcd(MAXT - int'($urandom_range(0, 3)));
            2: v = to_bcd(int'($urandom_range(0, 4)));
            3: begin v = to_bcd(int'($urandom_range(0, MAXT))); v[15:12] = 4'd6; end
            4: begin
                m = int'($urandom_range(MM + 1, 99));
                v = to_bcd(int'($urandom_range(0, 5999)));
                v[23:20] = 4'(m / 10);
                v[19:16] = 4'(m % 10);
            end
            default: v = 24'($urandom);
        endcase
        return v;
    endfunction

    task automatic random_run(input int n);
        logic ss, clr, lp, ld;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 199) == 0) dir_v = ~dir_v;
            ss  = ($urandom_range(0, 99) < 3);
            clr = ($urandom_range(0, 199) == 0);
            lp  = ($urandom_range(0, 99) < 3);
            ld  = ($urandom_range(0, 99) < 2);
            cycle(ss, clr, lp, ld, gen_load());
        end
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        bus_if.start_stop = 1'b0; bus_if.clear = 1'b0; bus_if.lap = 1'b0; bus_if.load_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus_if.start_stop = 1'b0; bus_if.clear = 1'b0; bus_if.lap = 1'b0;
        bus_if.dir = 1'b0; bus_if.load_en = 1'b0; bus_if.load_value = 24'd0;
        model_reset();
        #3;
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Up count from edge 10 through the 00:00.99 -> 00:01.00 carry.
        idle_n(9);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        idle_n(410);

        // Rollover from 59:59.98, then clear racing start_stop.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h595998);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        idle_n(14);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 24'd0);

        // Countdown to expiry; the later start_stop must be ignored.
        dir_v = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h000002);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        idle_n(10);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        idle_n(6);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);

        // Pause two cycles into a tick, hold, resume; then load validation in PAUSE and RUN.
        dir_v = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        idle_n(5);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        idle_n(9);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h006000);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h610000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        idle_n(6);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h000100);
        idle_n(3);

        // Lap at 00:00.05 while counting, then pause and lap to release.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        idle_n(21);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 24'd0);
        idle_n(20);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 24'd0);
        idle_n(4);

        random_run(4000);
        async_reset_check();
        random_run(1500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Parametrised BCD stopwatch/countdown core for the board-level stopwatch design: it sits between the debounced pushbutton pulses and the 7-segment scan driver. It owns its own tick prescaler, a run/pause/expired state machine, and six BCD digits formatted MM:SS.CC. It counts up or down, accepts a preset, and flags rollover and expiry. An optional lap register can freeze the display while counting continues.

## Interface
- TICK_DIV, 1_000_000, clk cycles per centisecond tick; legal range ≥2 (use 4 in simulation).
- MIN_MAX, 59, highest minute value, 1..99; up-count rolls over after MIN_MAX:59.99.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clk.
- start_stop  in  1  one-cycle pulse that toggles run/pause.
- clear  in  1  one-cycle pulse that zeroes digits and returns the FSM to IDLE.
- lap  in  1  one-cycle pulse that captures or releases the lap display.
- dir  in  1  0 = count up, 1 = count down; sampled on each tick.
- load_en  in  1  one-cycle pulse that loads load_value.
- load_value  in  24  packed BCD preset {m1,m0,s1,s0,c1,c0}.
- disp  out  24  packed BCD shown to the display, same nibble order.
- running  out  1  high in RUN.
- lap_active  out  1  high while disp is frozen.
- expired  out  1  one-cycle pulse on countdown reaching zero.
- wrap  out  1  one-cycle pulse on up-count rollover.
- load_err  out  1  one-cycle pulse when load_value is rejected.

## Operation
- States are IDLE, RUN, PAUSE and EXPIRED.
- Priority on the same cycle: clear > load_en > start_stop > lap.
- **IDLE:** start_stop moves to RUN, except in down mode with count 00:00.00, where it is ignored. load_en loads the preset.
- **RUN:** start_stop moves to PAUSE. load_en is ignored and does not raise load_err.
- **PAUSE:** start_stop returns to RUN. load_en loads the preset and stays in PAUSE.
- **EXPIRED:** start_stop is ignored. load_en loads the preset and moves to IDLE.
- **clear, from any state:** count = 0, prescaler = 0, lap released, next state IDLE.
- **Prescaler:** counts 0..TICK_DIV-1 only in RUN; a tick occurs on the cycle it equals TICK_DIV-1.
  - Cleared on IDLE→RUN.
  - Held, not cleared, across PAUSE, so the fractional tick is preserved.
- **Up count:** c0 through m0 use decimal carry. s1 wraps at 5. The minutes field wraps at MIN_MAX.
  - MIN_MAX:59.99 + 1 gives 00:00.00, pulses wrap, and stays in RUN.
- **Down count:** decimal borrow in each field.
  - The tick that produces 00:00.00 moves to EXPIRED and pulses expired on the same edge.
  - A 00:00.00 count never goes negative.
- **Load validation:** load_value is rejected if any nibble >9, s1 >5, c digits >9, or minutes >MIN_MAX.
  - A rejected load leaves the count unchanged and pulses load_err.
- **Lap:** see Configuration.
- **Outputs:** disp is the captured lap value when lap_active=1, otherwise the live count.

## Timing
- **Reset values:** disp=0, running=0, lap_active=0, expired=0, wrap=0, load_err=0, state IDLE, prescaler 0, lap register 0.
- All outputs are registered; no combinational path runs from any input to any output.
- start_stop at edge k:
  - running=1 after edge k.
  - First digit update at edge k+TICK_DIV.
  - Later updates every TICK_DIV cycles.
- A pause at edge p followed by a resume at edge r shifts later ticks by (r-p) cycles.
- Pulses (expired, wrap, load_err) are high for exactly one cycle, aligned with the edge that updates disp or state.
- load_en at edge k: disp shows the preset after edge k.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronous). The first action after deassertion needs a fresh start_stop.

## Configuration
- Macro: STOPWATCH_LAP_EN.
- **Defined:**
  - lap in RUN with lap_active=0 captures the live count and sets lap_active=1.
  - lap in RUN with lap_active=1 recaptures the live count.
  - lap in PAUSE, IDLE or EXPIRED releases the capture (lap_active=0).
  - Counting is unaffected by any of the above.
- **Undefined:** the lap input is ignored, lap_active is tied 0, no lap register is built, and disp is always the live count.

## Test plan
- **Up count (TICK_DIV=4):** start_stop at edge 10 → running=1 after edge 10; disp=00:00.01 after edge 14; 00:00.99→00:01.00 carry on the hundredth tick.
- **Rollover (MIN_MAX=59):** load 59:59.98, run up → 59:59.99, then 00:00.00 with wrap=1 for one cycle; running stays 1.
- **Countdown:** load 00:00.02, dir=1, start → 00:00.01, then 00:00.00 with expired=1 on that edge; state EXPIRED, running=0; a later start_stop has no effect.
- **Pause, clear and priority:**
  - Pause 2 cycles into a tick, hold 10 cycles, resume → next update 2 cycles after resume.
  - clear and start_stop on the same cycle → IDLE, disp=0.
- **Load validation:**
  - load 00:6 0.00 (s1=6) → load_err=1, disp unchanged.
  - load 61:00.00 with MIN_MAX=59 → load_err=1.
  - load during RUN → ignored, no load_err.
- **Lap (STOPWATCH_LAP_EN defined):**
  - lap at 00:00.05 → disp holds 00:00.05 while the live count advances.
  - Pause then lap → disp shows the live value, lap_active=0.
  - Without the macro, the same stimulus leaves disp live throughout.
